// File: rtl/rob_if.sv
// rob_if: bundles the dispatcher, CDB, query and commit signals of the reorder buffer.
// Ports: master = dispatcher/RS/LSB/regfile side, slave = the ROB itself.
// Signal names follow the core-wide naming used by the surrounding pipeline blocks.
interface rob_if;
  // allocation from dispatcher
  logic        enable_from_dsp;
  logic [31:0] pc_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic [1:0]  kind_from_dsp;
  logic        pred_jump_from_dsp;
  logic [4:0]  alloc_rob_id;
  // operand lookup
  logic [4:0]  query_j_id;
  logic [4:0]  query_k_id;
  logic        query_j_ready;
  logic        query_k_ready;
  logic [31:0] query_j_value;
  logic [31:0] query_k_value;
  // common data buses
  logic        enable_cdb_rs;
  logic [4:0]  cdb_rs_rob_id;
  logic [31:0] cdb_rs_value;
  logic        cdb_rs_jump;
  logic [31:0] cdb_rs_pc_next;
  logic        enable_cdb_lsb;
  logic [4:0]  cdb_lsb_rob_id;
  logic [31:0] cdb_lsb_value;
  // commit / redirect
  logic        commit_reg_en;
  logic [4:0]  commit_rd;
  logic [4:0]  commit_rob_id;
  logic [31:0] commit_value;
  logic        commit_store_en;
  logic [4:0]  commit_store_rob_id;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        full_rob;

  modport master (
    output enable_from_dsp, pc_from_dsp, rd_from_dsp, kind_from_dsp, pred_jump_from_dsp,
    output query_j_id, query_k_id,
    output enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value, cdb_rs_jump, cdb_rs_pc_next,
    output enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value,
    input  alloc_rob_id, query_j_ready, query_k_ready, query_j_value, query_k_value,
    input  commit_reg_en, commit_rd, commit_rob_id, commit_value,
    input  commit_store_en, commit_store_rob_id, mispredict, redirect_pc, full_rob
  );

  modport slave (
    input  enable_from_dsp, pc_from_dsp, rd_from_dsp, kind_from_dsp, pred_jump_from_dsp,
    input  query_j_id, query_k_id,
    input  enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value, cdb_rs_jump, cdb_rs_pc_next,
    input  enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value,
    output alloc_rob_id, query_j_ready, query_k_ready, query_j_value, query_k_value,
    output commit_reg_en, commit_rd, commit_rob_id, commit_value,
    output commit_store_en, commit_store_rob_id, mispredict, redirect_pc, full_rob
  );
endinterface

// File: rtl/rob.sv
// rob: 16-entry reorder buffer; in-order commit of one head entry per cycle, flush on mispredict.
// Ports: clk, rst (sync, active-high), rdy (global stall), bus (rob_if.slave: alloc, query, CDB, commit).
// Option: define ROB_CDB_BYPASS_EN to let queries see same-cycle CDB broadcasts.
module rob (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  rob_if.slave bus
);
  localparam int         N       = 16;
  localparam logic [4:0] NON_DEP = 5'd16;
  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JMP = 2'd3;

  logic [3:0]   head_q, head_d, tail_q, tail_d;
  logic [4:0]   count_q, count_d;
  logic [N-1:0] busy_q, busy_d, done_q, done_d;
  logic [1:0]   kind_q [N];
  logic [4:0]   rd_q   [N];
  logic [31:0]  val_q  [N];
  logic [31:0]  pcn_q  [N];
  logic [N-1:0] pj_q, jump_q;

  logic        creg_en_q, creg_en_d, cst_en_q, cst_en_d, mis_q, mis_d;
  logic [4:0]  crd_q, crd_d, crid_q, crid_d, cst_id_q, cst_id_d;
  logic [31:0] cval_q, cval_d, rpc_q, rpc_d;

  // The fetch pc travels with the entry only for tracing; redirect targets come from the RS.
  logic unused_pc;
  assign unused_pc = ^bus.pc_from_dsp;

  logic       do_alloc, rs_hit, lsb_hit, do_commit;
  logic [3:0] rs_idx, lsb_idx;
  assign rs_idx  = bus.cdb_rs_rob_id[3:0];
  assign lsb_idx = bus.cdb_lsb_rob_id[3:0];
  // Everything is frozen while the flush pulse is out, so the mispredict cycle is a clean bubble.
  assign do_alloc  = bus.enable_from_dsp && rdy && !mis_q && (count_q != 5'd16);
  assign rs_hit    = bus.enable_cdb_rs  && rdy && !mis_q && !bus.cdb_rs_rob_id[4]  && busy_q[rs_idx];
  assign lsb_hit   = bus.enable_cdb_lsb && rdy && !mis_q && !bus.cdb_lsb_rob_id[4] && busy_q[lsb_idx];
  assign do_commit = rdy && !mis_q && busy_q[head_q] && done_q[head_q];

  always_comb begin
    head_d = head_q; tail_d = tail_q;
    busy_d = busy_q; done_d = done_q;
    creg_en_d = 1'b0; crd_d = '0; crid_d = '0; cval_d = '0;
    cst_en_d = 1'b0; cst_id_d = '0; mis_d = 1'b0; rpc_d = rpc_q;
    if (do_alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d = tail_q + 4'd1;
    end
    if (rs_hit)  done_d[rs_idx]  = 1'b1;
    if (lsb_hit) done_d[lsb_idx] = 1'b1;
    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d = head_q + 4'd1;
      if ((kind_q[head_q] == K_ALU || kind_q[head_q] == K_JMP) && rd_q[head_q] != 5'd0) begin
        creg_en_d = 1'b1;
        crd_d     = rd_q[head_q];
        crid_d    = {1'b0, head_q};
        cval_d    = val_q[head_q];
      end
      if (kind_q[head_q] == K_ST) begin
        cst_en_d = 1'b1;
        cst_id_d = {1'b0, head_q};
      end
      // Jumps always redirect (target unknown at fetch); branches only on a wrong guess.
      if (kind_q[head_q] == K_JMP ||
          (kind_q[head_q] == K_BR && jump_q[head_q] != pj_q[head_q])) begin
        mis_d = 1'b1;
        rpc_d = pcn_q[head_q];
      end
    end
    count_d = count_q + {4'd0, do_alloc} - {4'd0, do_commit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0; tail_q <= '0; count_q <= '0; busy_q <= '0; done_q <= '0;
      creg_en_q <= 1'b0; crd_q <= '0; crid_q <= '0; cval_q <= '0;
      cst_en_q <= 1'b0; cst_id_q <= '0; mis_q <= 1'b0; rpc_q <= '0;
    end else begin
      if (mis_q) begin
        head_q <= '0; tail_q <= '0; count_q <= '0; busy_q <= '0; done_q <= '0;
      end else begin
        head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
        busy_q <= busy_d; done_q <= done_d;
      end
      creg_en_q <= creg_en_d; crd_q <= crd_d; crid_q <= crid_d; cval_q <= cval_d;
      cst_en_q <= cst_en_d; cst_id_q <= cst_id_d; mis_q <= mis_d; rpc_q <= rpc_d;
    end
  end

  // Payload needs no reset: busy/done gate every use of it.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      kind_q[tail_q] <= bus.kind_from_dsp;
      rd_q[tail_q]   <= bus.rd_from_dsp;
      pj_q[tail_q]   <= bus.pred_jump_from_dsp;
      jump_q[tail_q] <= 1'b0;
    end
    if (rs_hit) begin
      val_q[rs_idx]  <= bus.cdb_rs_value;
      jump_q[rs_idx] <= bus.cdb_rs_jump;
      pcn_q[rs_idx]  <= bus.cdb_rs_pc_next;
    end
    if (lsb_hit) val_q[lsb_idx] <= bus.cdb_lsb_value;
  end

  logic [4:0]  qid  [2];
  logic        qrdy [2];
  logic [31:0] qval [2];
  assign qid[0] = bus.query_j_id;
  assign qid[1] = bus.query_k_id;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qrdy[i] = 1'b0;
      qval[i] = '0;
      if (qid[i] == NON_DEP) begin
        qrdy[i] = 1'b1;
      end else if (!qid[i][4] && done_q[qid[i][3:0]]) begin
        qrdy[i] = 1'b1;
        qval[i] = val_q[qid[i][3:0]];
      end
`ifdef ROB_CDB_BYPASS_EN
      // LSB first so that an RS hit on the same id overrides it.
      if (bus.enable_cdb_lsb && qid[i] != NON_DEP && qid[i] == bus.cdb_lsb_rob_id) begin
        qrdy[i] = 1'b1;
        qval[i] = bus.cdb_lsb_value;
      end
      if (bus.enable_cdb_rs && qid[i] != NON_DEP && qid[i] == bus.cdb_rs_rob_id) begin
        qrdy[i] = 1'b1;
        qval[i] = bus.cdb_rs_value;
      end
`endif
    end
  end

  assign bus.query_j_ready       = qrdy[0];
  assign bus.query_j_value       = qval[0];
  assign bus.query_k_ready       = qrdy[1];
  assign bus.query_k_value       = qval[1];
  assign bus.alloc_rob_id        = {1'b0, tail_q};
  assign bus.full_rob            = (count_q == 5'd16);
  assign bus.commit_reg_en       = creg_en_q;
  assign bus.commit_rd           = crd_q;
  assign bus.commit_rob_id       = crid_q;
  assign bus.commit_value        = cval_q;
  assign bus.commit_store_en     = cst_en_q;
  assign bus.commit_store_rob_id = cst_id_q;
  assign bus.mispredict          = mis_q;
  assign bus.redirect_pc         = rpc_q;
endmodule

// File: tb/tb_rob.sv
module tb_rob;
  logic clk = 1'b0;
  logic rst, rdy;
  rob_if bus();
  rob dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] rd, input logic pj);
    bus.enable_from_dsp = 1'b1; bus.kind_from_dsp = k; bus.rd_from_dsp = rd;
    bus.pred_jump_from_dsp = pj; bus.pc_from_dsp = 32'h1000;
    tick;
    bus.enable_from_dsp = 1'b0;
  endtask

  task automatic rs_bcast(input logic [4:0] id, input logic [31:0] v, input logic j, input logic [31:0] pn);
    bus.enable_cdb_rs = 1'b1; bus.cdb_rs_rob_id = id; bus.cdb_rs_value = v;
    bus.cdb_rs_jump = j; bus.cdb_rs_pc_next = pn;
    tick;
    bus.enable_cdb_rs = 1'b0;
  endtask

  task automatic lsb_bcast(input logic [4:0] id, input logic [31:0] v);
    bus.enable_cdb_lsb = 1'b1; bus.cdb_lsb_rob_id = id; bus.cdb_lsb_value = v;
    tick;
    bus.enable_cdb_lsb = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.enable_from_dsp = 0; bus.pc_from_dsp = 0; bus.rd_from_dsp = 0;
    bus.kind_from_dsp = 0; bus.pred_jump_from_dsp = 0;
    bus.query_j_id = 5'd0; bus.query_k_id = 5'd16;
    bus.enable_cdb_rs = 0; bus.cdb_rs_rob_id = 0; bus.cdb_rs_value = 0;
    bus.cdb_rs_jump = 0; bus.cdb_rs_pc_next = 0;
    bus.enable_cdb_lsb = 0; bus.cdb_lsb_rob_id = 0; bus.cdb_lsb_value = 0;
    tick; tick;

    // reset state
    chk("rst_reg_en", bus.commit_reg_en, 0);
    chk("rst_st_en", bus.commit_store_en, 0);
    chk("rst_mis", bus.mispredict, 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    chk("rst_alloc_id", bus.alloc_rob_id, 0);
    chk("rst_full", bus.full_rob, 0);
    chk("rst_qj_ready", bus.query_j_ready, 0);
    chk("rst_qk_nondep_ready", bus.query_k_ready, 1);
    chk("rst_qk_nondep_value", bus.query_k_value, 0);
    rst = 1'b0;

    // basic alloc -> broadcast -> commit
    alloc(2'd0, 5'd5, 1'b0);
    chk("a0_alloc_id", bus.alloc_rob_id, 1);
    rs_bcast(5'd0, 32'h2A, 1'b0, 32'h0);
    chk("a0_no_early_commit", bus.commit_reg_en, 0);
    chk("a0_q_ready", bus.query_j_ready, 1);
    chk("a0_q_value", bus.query_j_value, 32'h2A);
    tick;
    chk("a0_reg_en", bus.commit_reg_en, 1);
    chk("a0_rd", bus.commit_rd, 5);
    chk("a0_id", bus.commit_rob_id, 0);
    chk("a0_value", bus.commit_value, 32'h2A);
    tick;
    chk("a0_pulse_end", bus.commit_reg_en, 0);

    // out-of-order completion, in-order commit (ids 1 and 2)
    alloc(2'd0, 5'd1, 1'b0);
    alloc(2'd0, 5'd2, 1'b0);
    rs_bcast(5'd2, 32'h22, 1'b0, 32'h0);
    chk("ooo_hold", bus.commit_reg_en, 0);
    lsb_bcast(5'd1, 32'h11);
    tick;
    chk("ooo_first_id", bus.commit_rob_id, 1);
    chk("ooo_first_val", bus.commit_value, 32'h11);
    tick;
    chk("ooo_second_en", bus.commit_reg_en, 1);
    chk("ooo_second_id", bus.commit_rob_id, 2);
    chk("ooo_second_val", bus.commit_value, 32'h22);

    // store + rd=0 ALU, both CDBs in one cycle (ids 3 and 4)
    alloc(2'd2, 5'd0, 1'b0);
    alloc(2'd0, 5'd0, 1'b0);
    bus.enable_cdb_rs = 1; bus.cdb_rs_rob_id = 5'd4; bus.cdb_rs_value = 32'h44;
    bus.enable_cdb_lsb = 1; bus.cdb_lsb_rob_id = 5'd3; bus.cdb_lsb_value = 32'h33;
    tick;
    bus.enable_cdb_rs = 0; bus.enable_cdb_lsb = 0;
    tick;
    chk("st_en", bus.commit_store_en, 1);
    chk("st_id", bus.commit_store_rob_id, 3);
    chk("st_no_reg", bus.commit_reg_en, 0);
    tick;
    chk("rd0_no_reg", bus.commit_reg_en, 0);
    chk("rd0_no_st", bus.commit_store_en, 0);

    // fill to 16, overflow alloc ignored, wrap
    do_reset;
    bus.enable_from_dsp = 1; bus.kind_from_dsp = 2'd0; bus.rd_from_dsp = 5'd7;
    for (int i = 0; i < 16; i++) tick;
    chk("full_set", bus.full_rob, 1);
    chk("full_alloc_id", bus.alloc_rob_id, 0);
    tick;
    chk("full_17_ignored_full", bus.full_rob, 1);
    chk("full_17_ignored_id", bus.alloc_rob_id, 0);
    bus.enable_from_dsp = 0;
    rs_bcast(5'd0, 32'h5, 1'b0, 32'h0);
    tick;
    chk("full_commit_en", bus.commit_reg_en, 1);
    chk("full_commit_rd", bus.commit_rd, 7);
    chk("full_commit_val", bus.commit_value, 5);
    chk("full_cleared", bus.full_rob, 0);
    chk("full_wrap_id", bus.alloc_rob_id, 0);

    // branch mispredict flushes younger ready entries
    do_reset;
    alloc(2'd1, 5'd0, 1'b0);
    alloc(2'd0, 5'd3, 1'b0);
    alloc(2'd0, 5'd4, 1'b0);
    bus.enable_cdb_rs = 1; bus.cdb_rs_rob_id = 5'd1; bus.cdb_rs_value = 32'h9;
    bus.cdb_rs_jump = 0; bus.cdb_rs_pc_next = 0;
    bus.enable_cdb_lsb = 1; bus.cdb_lsb_rob_id = 5'd2; bus.cdb_lsb_value = 32'hA;
    tick;
    bus.enable_cdb_rs = 0; bus.enable_cdb_lsb = 0;
    rs_bcast(5'd0, 32'h0, 1'b1, 32'h100);
    bus.enable_from_dsp = 1; bus.kind_from_dsp = 2'd0; bus.rd_from_dsp = 5'd9;
    tick;
    chk("mp_pulse", bus.mispredict, 1);
    chk("mp_rpc", bus.redirect_pc, 32'h100);
    chk("mp_br_no_reg", bus.commit_reg_en, 0);
    tick;
    bus.enable_from_dsp = 0;
    chk("mp_one_cycle", bus.mispredict, 0);
    chk("mp_flush_no_commit", bus.commit_reg_en, 0);
    chk("mp_flush_tail", bus.alloc_rob_id, 0);
    chk("mp_rpc_hold", bus.redirect_pc, 32'h100);
    tick;
    bus.query_j_id = 5'd1;
    #1;
    chk("mp_young_never", bus.commit_reg_en, 0);
    chk("mp_young_gone", bus.query_j_ready, 0);

    // correct branch, then jump always redirects and writes rd
    alloc(2'd1, 5'd0, 1'b1);
    alloc(2'd3, 5'd1, 1'b0);
    rs_bcast(5'd0, 32'h0, 1'b1, 32'h80);
    rs_bcast(5'd1, 32'h44, 1'b0, 32'h200);
    chk("br_ok_no_mp", bus.mispredict, 0);
    chk("br_ok_no_reg", bus.commit_reg_en, 0);
    tick;
    chk("jmp_reg_en", bus.commit_reg_en, 1);
    chk("jmp_rd", bus.commit_rd, 1);
    chk("jmp_val", bus.commit_value, 32'h44);
    chk("jmp_mp", bus.mispredict, 1);
    chk("jmp_rpc", bus.redirect_pc, 32'h200);
    tick;
    chk("jmp_flush_id", bus.alloc_rob_id, 0);

    // query bypass behaviour
    alloc(2'd0, 5'd6, 1'b0);
    alloc(2'd0, 5'd8, 1'b0);
    alloc(2'd0, 5'd0, 1'b0);
    alloc(2'd0, 5'd0, 1'b0);
    bus.query_j_id = 5'd3;
    bus.enable_cdb_rs = 1; bus.cdb_rs_rob_id = 5'd3; bus.cdb_rs_value = 32'h7;
    bus.cdb_rs_jump = 0; bus.cdb_rs_pc_next = 0;
    #1;
    chk("byp_ready", bus.query_j_ready, BYP ? 32'd1 : 32'd0);
    chk("byp_value", bus.query_j_value, BYP ? 32'd7 : 32'd0);
    tick;
    bus.enable_cdb_rs = 0;
    #1;
    chk("q_reg_ready", bus.query_j_ready, 1);
    chk("q_reg_value", bus.query_j_value, 7);

    // stall holds a ready head
    rs_bcast(5'd0, 32'h1, 1'b0, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_no_commit", bus.commit_reg_en, 0);
    end
    rdy = 1'b1;
    tick;
    chk("stall_release_en", bus.commit_reg_en, 1);
    chk("stall_release_rd", bus.commit_rd, 6);

    // reset mid-stream abandons the pending commit of id 1
    rs_bcast(5'd1, 32'h2, 1'b0, 32'h0);
    rst = 1'b1;
    tick;
    bus.query_j_id = 5'd1;
    #1;
    chk("mrst_reg_en", bus.commit_reg_en, 0);
    chk("mrst_val", bus.commit_value, 0);
    chk("mrst_rpc", bus.redirect_pc, 0);
    chk("mrst_alloc_id", bus.alloc_rob_id, 0);
    chk("mrst_q_ready", bus.query_j_ready, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
